// File: rtl/d_latch.sv
// rtl/d_latch.sv - complementary-phase transparent latch with inverted output; D_LATCH_PHASE_CHECK_EN adds a sticky phase fault flag
`timescale 1ns/1ps

module d_latch #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] q_bar,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             clk_bar,
    input  logic             rst
`ifdef D_LATCH_PHASE_CHECK_EN
    ,
    output logic             phase_err
`endif
);

    logic             rst_q;
    logic             phase_open;
    logic [WIDTH-1:0] store;

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Both phases must agree before the latch opens; either one closing shuts it.
    assign phase_open = clk & ~clk_bar & ~rst_q;

    // Registered reset dominates; the latch is otherwise only written while open.
    always_latch begin
        if (rst_q) begin
            store <= RESET_VAL;
        end else if (phase_open) begin
            store <= d;
        end
    end

    assign q_bar = ~store;

`ifdef D_LATCH_PHASE_CHECK_EN
    logic phase_bad;

    assign phase_bad = (clk == clk_bar);

    // Level-sensitive so a fault of any duration is caught, not only across an edge.
    always_latch begin
        if (rst_q) begin
            phase_err <= 1'b0;
        end else if (phase_bad) begin
            phase_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - directed self-checking bench for d_latch
`timescale 1ns/1ps

module tb_d_latch;

    logic       clk;
    logic       clk_bar;
    logic       rst;
    logic       d;
    logic       q_bar;
    logic [7:0] d8;
    logic [7:0] q8;
`ifdef D_LATCH_PHASE_CHECK_EN
    logic       phase_err;
    logic       phase_err8;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    d_latch dut (
        .q_bar     (q_bar),
        .d         (d),
        .clk       (clk),
        .clk_bar   (clk_bar),
        .rst       (rst)
`ifdef D_LATCH_PHASE_CHECK_EN
        ,
        .phase_err (phase_err)
`endif
    );

    d_latch #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut8 (
        .q_bar     (q8),
        .d         (d8),
        .clk       (clk),
        .clk_bar   (clk_bar),
        .rst       (rst)
`ifdef D_LATCH_PHASE_CHECK_EN
        ,
        .phase_err (phase_err8)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rise();
        clk     = 1'b1;
        clk_bar = 1'b0;
        #1;
    endtask

    task automatic fall();
        clk     = 1'b0;
        clk_bar = 1'b1;
        #1;
    endtask

    initial begin
        clk     = 1'b0;
        clk_bar = 1'b1;
        rst     = 1'b1;
        d       = 1'b0;
        d8      = 8'h00;
        #1;

        // Reset taken at the rising edge, d=1 ignored through the high phase
        d  = 1'b1;
        rise();
        chk("reset_q_bar", {7'd0, q_bar}, 8'h01);
        chk("reset_q8", q8, 8'h5A);
        d8 = 8'h33;
        #1;
        chk("reset_hold_high", {7'd0, q_bar}, 8'h01);
        chk("reset_hold_q8", q8, 8'h5A);
`ifdef D_LATCH_PHASE_CHECK_EN
        chk("phase_err_reset", {7'd0, phase_err}, 8'h00);
`endif
        rst = 1'b0;
        #1;
        chk("rst_release_waits_edge", {7'd0, q_bar}, 8'h01);
        fall();
        chk("reset_low_phase", {7'd0, q_bar}, 8'h01);

        // Release takes effect at the next rising edge
        rise();
        chk("release_transparent", {7'd0, q_bar}, 8'h00);

        // Transparency tracks each change of d
        d = 1'b0; #1; chk("transp_0", {7'd0, q_bar}, 8'h01);
        d = 1'b1; #1; chk("transp_1", {7'd0, q_bar}, 8'h00);
        d = 1'b0; #1; chk("transp_2", {7'd0, q_bar}, 8'h01);
        d = 1'b1; #1; chk("transp_3", {7'd0, q_bar}, 8'h00);

        d8 = 8'h0F; #1; chk("w8_transp_0f", q8, 8'hF0);
        d8 = 8'h3C; #1; chk("w8_transp_3c", q8, 8'hC3);
        d8 = 8'h0F; #1;

        // Hold: close with d=1, toggle d during low phase
        d = 1'b1;
        fall();
        chk("hold_close", {7'd0, q_bar}, 8'h00);
        d = 1'b0; #1; chk("hold_d0", {7'd0, q_bar}, 8'h00);
        d = 1'b1; #1; chk("hold_d1", {7'd0, q_bar}, 8'h00);
        d = 1'b1; #1; chk("hold_d1b", {7'd0, q_bar}, 8'h00);
        d8 = 8'hFF; #1; chk("w8_hold", q8, 8'hF0);
        rise();
        chk("reopen_d1", {7'd0, q_bar}, 8'h00);
        chk("w8_reopen", q8, 8'h00);
        d = 1'b0; #1; chk("reopen_d0", {7'd0, q_bar}, 8'h01);

        // Invalid phases hold the stored value
        clk_bar = 1'b1;
        d = 1'b1; #1; chk("invalid_11", {7'd0, q_bar}, 8'h01);
`ifdef D_LATCH_PHASE_CHECK_EN
        chk("phase_err_set", {7'd0, phase_err}, 8'h01);
`endif
        clk_bar = 1'b0;
        clk     = 1'b0;
        #1; chk("invalid_00", {7'd0, q_bar}, 8'h01);
        clk_bar = 1'b1;
        #1; chk("opaque_after_invalid", {7'd0, q_bar}, 8'h01);
`ifdef D_LATCH_PHASE_CHECK_EN
        chk("phase_err_sticky", {7'd0, phase_err}, 8'h01);
`endif
        rise();
        chk("valid_after_invalid", {7'd0, q_bar}, 8'h00);

        // Reset raised mid high phase has no effect until the next edge
        rst = 1'b1;
        d = 1'b0; #1; chk("rst_mid_high_0", {7'd0, q_bar}, 8'h01);
        d = 1'b1; #1; chk("rst_mid_high_1", {7'd0, q_bar}, 8'h00);
        fall();
        rise();
        chk("rst_edge_taken", {7'd0, q_bar}, 8'h01);
        chk("rst_edge_q8", q8, 8'h5A);
`ifdef D_LATCH_PHASE_CHECK_EN
        chk("phase_err_cleared", {7'd0, phase_err}, 8'h00);
`endif
        rst = 1'b0;
        fall();
        rise();
        chk("second_release", {7'd0, q_bar}, 8'h00);
        d8 = 8'h81; #1; chk("w8_after_release", q8, 8'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter WIDTH, default 1: data bit width.
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}: stored value loaded by reset.
REQ-003 Port clk  input  1: latch-enable clock phase and sole clock; one clock only.
REQ-004 Port rst  input  1: reset, synchronous to rising edge of clk, active-high.
REQ-005 Port clk_bar  input  1: complementary enable phase; nominally ~clk.
REQ-006 Port d  input  WIDTH: data in.
REQ-007 Port q_bar  output  WIDTH: inverted stored or transparent data.
REQ-008 Port phase_err  output  1: sticky phase fault flag; present only with the configuration macro.
REQ-009 Positional declaration order SHALL be q_bar, d, clk, clk_bar, rst, then phase_err if present, so existing 4-port positional instances stay valid.

Function
REQ-010 Internal rst_q SHALL be rst registered on every rising clk edge.
REQ-011 Transparent mode: clk=1, clk_bar=0, rst_q=0; q_bar SHALL equal ~d combinationally, with no cycle delay.
REQ-012 Opaque mode: clk=0, clk_bar=1; q_bar SHALL hold ~d as captured at the instant the latch closed; d changes SHALL be ignored.
REQ-013 Invalid phase: clk==clk_bar; latch SHALL be opaque and hold its stored value.
REQ-014 Closing either phase signal alone SHALL close the latch; both must be in the open state to open it.
REQ-015 Operation SHALL be bitwise and independent per bit; no arithmetic, no width conversion.
REQ-016 d changing at the same time the latch closes: the value present before the closing edge SHALL be captured.
REQ-017 q_bar SHALL never glitch in opaque mode.

Reset
REQ-018 rst=1 at a rising clk edge SHALL set the stored value to RESET_VAL, so q_bar=~RESET_VAL; the default gives all ones.
REQ-019 While rst_q=1, transparency SHALL be suppressed and q_bar SHALL hold ~RESET_VAL regardless of d or phase.
REQ-020 rst deassertion SHALL take effect at the next rising clk edge; transparency resumes in that high phase.
REQ-021 rst asserted mid high phase SHALL have no effect until the next rising clk edge.
REQ-022 Before the first reset, q_bar is undefined and SHALL NOT be checked.
REQ-023 Reset SHALL clear phase_err when it is present.

Configuration
REQ-024 Macro D_LATCH_PHASE_CHECK_EN defined: phase_err port SHALL exist, reset to 0.
REQ-025 With the macro, phase_err SHALL set to 1 on any interval where clk==clk_bar while rst_q=0.
REQ-026 With the macro, phase_err SHALL stay 1 until reset.
REQ-027 Macro undefined: phase_err port SHALL be absent; REQ-013 hold behaviour SHALL still apply.

Verification
REQ-028 Transparency: reset, then clk=1, clk_bar=0; d 0->1->0->1 at 1-unit steps -> q_bar 1->0->1->0, tracking each change immediately.
REQ-029 Hold: d=1 when clk falls (clk_bar rises); d toggles 0,1,1 during low phase -> q_bar stays 0; on next clk rise with d=1, q_bar=0, then d=0 gives q_bar=1.
REQ-030 Reset: rst=1 across rising clk edge with d=1 -> q_bar=1 (RESET_VAL=0) through the whole high phase.
REQ-031 Reset release: rst=0 before next rising edge -> q_bar=~d from that edge onward.
REQ-032 Width: WIDTH=8, RESET_VAL=8'hA5, reset -> q_bar=8'h5A; transparent d=8'h0F -> q_bar=8'hF0; close, d=8'hFF -> q_bar stays 8'hF0.
REQ-033 Phase fault with D_LATCH_PHASE_CHECK_EN: force clk=clk_bar=1 for 1 unit -> q_bar unchanged, phase_err=1 and sticky; rst at next rising edge -> phase_err=0.
